io_port_bridge: RTL and testbench
=================================

// Module: io_port_bridge
// PURPOSE
//  Peripheral-side partner of the core's accumulator datapath port pair. Sinks bytes the core stores to
//  register 0 (OPORT) into a TX FIFO drained over a valid/ready stream. Sources bytes from an external
//  valid/ready stream into an RX FIFO presented on IPORT (register 1), with MSB = "empty" so firmware
//  polls with load + branch-if-negative. Sits between datapath and board-level I/O / testbench host.
// PARAMETERS
//  DATA_LEN    8   port width; RX payload is DATA_LEN-1 bits (MSB reserved for empty flag)
//  FIFO_DEPTH  4   entries per FIFO; power of two, >= 2
//  PTR_LEN     2   log2(FIFO_DEPTH); derived, not overridden
// PORTS
//  CLK       in   1           clock, all state on posedge
//  RSTN      in   1           reset: asynchronous, active-low
//  OPORT     in   DATA_LEN    register-0 contents from the datapath register file
//  PORT_WR   in   1           core store to register 0 this cycle (IS_ST & REG_ID==0)
//  PORT_RD   in   1           core load from register 1 this cycle (IS_LD & ~LD_SEL & REG_ID==1)
//  IPORT     out  DATA_LEN    {rx_empty, rx_head[DATA_LEN-2:0]} into register 1
//  TX_DATA   out  DATA_LEN    TX FIFO head
//  TX_VALID  out  1           TX FIFO non-empty
//  TX_READY  in   1           external sink accepts TX_DATA
//  RX_DATA   in   DATA_LEN-1  external byte payload
//  RX_VALID  in   1           RX_DATA valid
//  RX_READY  out  1           RX FIFO not full
//  TX_OVF    out  1           sticky: core store dropped because TX FIFO full
//  OVF_CLR   in   1           synchronous clear of TX_OVF
// BEHAVIOUR
//  Reset (RSTN low, async): both FIFOs empty, pointers/counts 0, wr_q=0, TX_OVF=0.
//   Outputs during/after reset: IPORT=8'h80, TX_VALID=0, TX_DATA=0 (mem don't-care, head masked to 0
//   when empty), RX_READY=1. Reset mid-transfer discards all queued data; no partial handshakes survive.
//  TX path: register file updates OPORT at the same edge as the store, so wr_q<=PORT_WR; push of
//   OPORT happens at the edge where wr_q=1 (1-cycle delay; store-to-TX_VALID latency = 2 edges).
//   Push when full: byte dropped, TX_OVF<=1 at that edge. Back-to-back stores each push (wr_q per cycle).
//   Pop when TX_VALID & TX_READY. Simultaneous push+pop when full: both occur, count unchanged, no OVF.
//   TX_OVF: OVF_CLR has priority over a same-cycle set only if no overflow occurs that cycle (set wins).
//  RX path: push RX_DATA when RX_VALID & RX_READY. RX_READY = ~rx_full (combinational from count).
//   Pop at edge when PORT_RD & ~rx_empty; PORT_RD while empty is ignored (no underflow, no flag).
//   IPORT is combinational from FIFO state: empty -> 8'h80; else {1'b0, head}. Core samples IPORT and
//   pops on the same edge. Push+pop same edge when full: allowed only if RX_READY was 1, i.e. never
//   when full (ready low) -> pop only; when empty, push only (head visible next cycle, no bypass).
//  FIFO arithmetic: PTR_LEN-bit pointers wrap modulo FIFO_DEPTH; count is PTR_LEN+1 bits,
//   full = (count==FIFO_DEPTH), empty = (count==0). No combinational path RX_VALID->RX_READY,
//   TX_READY->TX_VALID.
// STRUCTURE
//  Shared params.v: `DATA_LEN, `IO_FIFO_DEPTH, `IO_EMPTY_FLAG (8'h80), `OPORT_REG_ID (2'd0),
//   `IPORT_REG_ID (2'd1).
//  One sub-module: sync_fifo #(WIDTH, DEPTH) — push/pop/full/empty/head, async active-low reset;
//   instantiated twice (tx_fifo width DATA_LEN, rx_fifo width DATA_LEN-1). Bridge adds wr_q, OVF,
//   IPORT encoding.
// TESTING
//  1 Reset: assert RSTN=0 mid-stream with 3 TX/2 RX queued -> IPORT=8'h80, TX_VALID=0, RX_READY=1,
//    TX_OVF=0 immediately (async), nothing emitted after release.
//  2 TX order: stores 8'h11,8'h22,8'hF3 on consecutive cycles, TX_READY=0 -> TX_VALID rises 2 edges
//    after first store; then TX_READY=1 -> TX_DATA 11,22,F3 on successive cycles, TX_VALID falls.
//  3 TX overflow: TX_READY=0, 5 stores (depth 4) -> 5th dropped, TX_OVF=1 sticky; drain yields 4
//    bytes; OVF_CLR pulse -> TX_OVF=0; OVF_CLR same cycle as new overflow -> TX_OVF stays 1.
//  4 RX fill/poll: send 7'h05,7'h7F; PORT_RD twice -> IPORT 8'h05 then 8'h7F then 8'h80; extra
//    PORT_RD on empty leaves IPORT=8'h80, count 0.
//  5 RX full + wrap: RX_VALID held high 6 cycles, no reads -> 4 accepted, RX_READY=0 after 4th;
//    PORT_RD pop -> RX_READY=1 next cycle; repeat 3 rounds to exercise pointer wrap, data in order.
//  6 Concurrent: TX push+pop when full and RX push+pop at count 2 same edge -> counts unchanged,
//    no OVF, data order preserved end-to-end.

Source files
------------

// File: rtl/io_port_bridge_pkg.sv
// Shared widths, FIFO sizing and the IPORT encoding for the I/O port bridge.
// Exports: DATA_LEN, RX_LEN, IO_FIFO_DEPTH, PTR_LEN, IO_EMPTY_FLAG, port_dat_t, rx_dat_t,
//          iport_encode(). Register decode (store to reg 0, load from reg 1) happens in the core.
package io_port_bridge_pkg;

    localparam int DATA_LEN      = 8;
    localparam int RX_LEN        = DATA_LEN - 1;
    localparam int IO_FIFO_DEPTH = 4;
    localparam int PTR_LEN       = $clog2(IO_FIFO_DEPTH);

    typedef logic [DATA_LEN-1:0] port_dat_t;
    typedef logic [RX_LEN-1:0]   rx_dat_t;

    localparam port_dat_t IO_EMPTY_FLAG = port_dat_t'(1) << (DATA_LEN - 1);

    // MSB set means "no byte waiting", so firmware can poll with load + branch-if-negative.
    function automatic port_dat_t iport_encode(input logic empty, input rx_dat_t head);
        return empty ? IO_EMPTY_FLAG : {1'b0, head};
    endfunction

endpackage

// File: rtl/io_port_bridge_if.sv
// Bundle of the datapath-facing and stream-facing signals of the I/O port bridge.
// slave  : the bridge (drives iport, tx_data/tx_valid, rx_ready, tx_ovf).
// master : datapath + board/host side (drives oport, strobes, tx_ready, rx stream, ovf_clr).
interface io_port_bridge_if;
    import io_port_bridge_pkg::*;

    port_dat_t oport;      // register-0 contents
    logic      port_wr;    // store to register 0 this cycle
    logic      port_rd;    // load from register 1 this cycle
    port_dat_t iport;      // {rx_empty, rx_head} into register 1
    port_dat_t tx_data;
    logic      tx_valid;
    logic      tx_ready;
    rx_dat_t   rx_data;
    logic      rx_valid;
    logic      rx_ready;
    logic      tx_ovf;     // sticky TX overflow
    logic      ovf_clr;

    modport slave (
        input  oport, port_wr, port_rd, tx_ready, rx_data, rx_valid, ovf_clr,
        output iport, tx_data, tx_valid, rx_ready, tx_ovf
    );

    modport master (
        output oport, port_wr, port_rd, tx_ready, rx_data, rx_valid, ovf_clr,
        input  iport, tx_data, tx_valid, rx_ready, tx_ovf
    );

endinterface

// File: rtl/io_port_bridge_sync_fifo.sv
// Synchronous FIFO, head visible combinationally (masked to 0 when empty).
// Latency: push visible at head one edge later; no bypass from dat_i to dat_o.
// Backpressure: push ignored when full unless a pop happens on the same edge; pop ignored when empty.
// Ports: clk, rst_n, push_i, pop_i, dat_i -> dat_o, full_o, empty_o.
module io_port_bridge_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] dat_i,
    output logic [WIDTH-1:0] dat_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_LEN = $clog2(DEPTH);
    localparam int CNT_LEN = PTR_LEN + 1;
    localparam logic [CNT_LEN-1:0] FULL_CNT = CNT_LEN'(DEPTH);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [PTR_LEN-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_LEN-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_LEN-1:0] count_q, count_d;
    logic               do_push;
    logic               do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);

    // A pop frees the slot the same edge, so a push into a full FIFO still lands.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset: contents are only observable through a non-empty head.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= dat_i;
    end

    assign dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/io_port_bridge.sv
// Bridges core register 0 stores to a TX stream and an RX stream to register 1 loads.
// Latency: store-to-tx_valid 2 edges; rx push-to-iport 1 edge; iport/tx_valid/rx_ready are from state only.
// Backpressure: tx_ready stalls TX (full FIFO drops stores, sets sticky tx_ovf); rx_ready low when RX full.
// Ports: clk, rst_n, port_if (io_port_bridge_if.slave).
module io_port_bridge
    import io_port_bridge_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    io_port_bridge_if.slave   port_if
);

    logic      wr_q;
    logic      ovf_q, ovf_d;
    logic      tx_full, tx_empty, tx_pop, tx_drop;
    logic      rx_full, rx_empty, rx_push, rx_pop;
    port_dat_t tx_head;
    rx_dat_t   rx_head;

    // The register file takes the stored value on the store edge, so oport is only
    // valid one cycle later; wr_q lines the push up with that value.
    assign tx_pop  = ~tx_empty & port_if.tx_ready;
    assign tx_drop = wr_q & tx_full & ~tx_pop;

    // A same-cycle overflow beats a clear so no drop goes unreported.
    always_comb begin
        ovf_d = ovf_q;
        if (port_if.ovf_clr) ovf_d = 1'b0;
        if (tx_drop)         ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            wr_q  <= port_if.port_wr;
            ovf_q <= ovf_d;
        end
    end

    io_port_bridge_sync_fifo #(.WIDTH(DATA_LEN), .DEPTH(IO_FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (wr_q),
        .pop_i   (tx_pop),
        .dat_i   (port_if.oport),
        .dat_o   (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    assign rx_push = port_if.rx_valid & ~rx_full;
    assign rx_pop  = port_if.port_rd & ~rx_empty;

    io_port_bridge_sync_fifo #(.WIDTH(RX_LEN), .DEPTH(IO_FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (rx_push),
        .pop_i   (rx_pop),
        .dat_i   (port_if.rx_data),
        .dat_o   (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    assign port_if.tx_data  = tx_head;
    assign port_if.tx_valid = ~tx_empty;
    assign port_if.rx_ready = ~rx_full;
    assign port_if.iport    = iport_encode(rx_empty, rx_head);
    assign port_if.tx_ovf   = ovf_q;

endmodule

// File: tb/tb_io_port_bridge.sv
// Directed-vector bench for io_port_bridge with hand-computed expectations.
// Inputs change 1 time unit after a rising edge; outputs are checked there, away from the edge.
// Prints one summary line with vector and miscompare counts.
module tb_io_port_bridge;
    import io_port_bridge_pkg::*;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    logic [7:0] st_q [8];

    io_port_bridge_if bus ();

    io_port_bridge dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .port_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Back-to-back stores of st_q[0..n-1]; oport follows one edge after each store.
    // Caller steps once more so the last store is pushed.
    task automatic do_stores(input int n);
        for (int i = 0; i < n; i++) begin
            bus.port_wr = 1'b1;
            step();
            bus.oport = st_q[i];
        end
        bus.port_wr = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.oport    = '0;
        bus.port_wr  = 1'b0;
        bus.port_rd  = 1'b0;
        bus.tx_ready = 1'b0;
        bus.rx_data  = '0;
        bus.rx_valid = 1'b0;
        bus.ovf_clr  = 1'b0;

        // Reset state
        #2;
        check_vec("rst iport",    32'(bus.iport),    32'h80);
        check_vec("rst tx_valid", 32'(bus.tx_valid), 32'h0);
        check_vec("rst tx_data",  32'(bus.tx_data),  32'h0);
        check_vec("rst rx_ready", 32'(bus.rx_ready), 32'h1);
        check_vec("rst tx_ovf",   32'(bus.tx_ovf),   32'h0);
        #10 rst_n = 1'b1;
        step();

        // TX order and store-to-valid latency
        bus.port_wr = 1'b1;
        step();
        bus.oport = 8'h11;
        check_vec("t2 vld after 1 edge", 32'(bus.tx_valid), 32'h0);
        step();
        bus.oport = 8'h22;
        check_vec("t2 vld after 2 edges", 32'(bus.tx_valid), 32'h1);
        check_vec("t2 head 11", 32'(bus.tx_data), 32'h11);
        step();
        bus.oport = 8'hF3;
        bus.port_wr = 1'b0;
        step();
        step();
        check_vec("t2 head held", 32'(bus.tx_data), 32'h11);
        bus.tx_ready = 1'b1;
        step();
        check_vec("t2 data 22", 32'(bus.tx_data), 32'h22);
        step();
        check_vec("t2 data F3", 32'(bus.tx_data), 32'hF3);
        check_vec("t2 vld F3",  32'(bus.tx_valid), 32'h1);
        step();
        check_vec("t2 vld falls", 32'(bus.tx_valid), 32'h0);
        check_vec("t2 data masked", 32'(bus.tx_data), 32'h0);
        bus.tx_ready = 1'b0;

        // TX overflow
        st_q[0] = 8'hA1; st_q[1] = 8'hA2; st_q[2] = 8'hA3; st_q[3] = 8'hA4; st_q[4] = 8'hA5;
        do_stores(5);
        check_vec("t3 ovf before drop", 32'(bus.tx_ovf), 32'h0);
        step();
        check_vec("t3 ovf set", 32'(bus.tx_ovf), 32'h1);
        step();
        step();
        check_vec("t3 ovf sticky", 32'(bus.tx_ovf), 32'h1);
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_vec("t3 drain", 32'(bus.tx_data), 32'(st_q[i]));
            step();
        end
        check_vec("t3 drained", 32'(bus.tx_valid), 32'h0);
        bus.tx_ready = 1'b0;
        bus.ovf_clr = 1'b1;
        step();
        bus.ovf_clr = 1'b0;
        check_vec("t3 ovf cleared", 32'(bus.tx_ovf), 32'h0);
        st_q[0] = 8'hB1; st_q[1] = 8'hB2; st_q[2] = 8'hB3; st_q[3] = 8'hB4;
        do_stores(4);
        step();
        check_vec("t3 full no ovf", 32'(bus.tx_ovf), 32'h0);
        bus.port_wr = 1'b1;
        step();
        bus.oport = 8'hC5;
        bus.port_wr = 1'b0;
        bus.ovf_clr = 1'b1;
        step();
        bus.ovf_clr = 1'b0;
        check_vec("t3 set beats clr", 32'(bus.tx_ovf), 32'h1);
        check_vec("t3 head kept", 32'(bus.tx_data), 32'hB1);
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        bus.tx_ready = 1'b0;
        check_vec("t3 empty again", 32'(bus.tx_valid), 32'h0);
        bus.ovf_clr = 1'b1;
        step();
        bus.ovf_clr = 1'b0;

        // RX fill / poll
        bus.rx_valid = 1'b1;
        bus.rx_data = 7'h05;
        step();
        bus.rx_data = 7'h7F;
        step();
        bus.rx_valid = 1'b0;
        check_vec("t4 iport 05", 32'(bus.iport), 32'h05);
        bus.port_rd = 1'b1;
        step();
        check_vec("t4 iport 7F", 32'(bus.iport), 32'h7F);
        step();
        check_vec("t4 iport empty", 32'(bus.iport), 32'h80);
        step();
        bus.port_rd = 1'b0;
        check_vec("t4 rd on empty", 32'(bus.iport), 32'h80);
        check_vec("t4 ready", 32'(bus.rx_ready), 32'h1);
        bus.rx_valid = 1'b1;
        bus.rx_data = 7'h33;
        step();
        bus.rx_valid = 1'b0;
        check_vec("t4 no underflow", 32'(bus.iport), 32'h33);
        bus.port_rd = 1'b1;
        step();
        bus.port_rd = 1'b0;
        check_vec("t4 single entry", 32'(bus.iport), 32'h80);

        // RX full and pointer wrap
        for (int r = 0; r < 3; r++) begin
            bus.rx_valid = 1'b1;
            for (int i = 0; i < 6; i++) begin
                bus.rx_data = 7'(r * 16 + i);
                step();
                if (i == 2) check_vec("t5 ready at 3", 32'(bus.rx_ready), 32'h1);
                if (i == 3) check_vec("t5 full at 4", 32'(bus.rx_ready), 32'h0);
            end
            bus.rx_valid = 1'b0;
            check_vec("t5 head", 32'(bus.iport), 32'(r * 16));
            bus.port_rd = 1'b1;
            step();
            bus.port_rd = 1'b0;
            check_vec("t5 ready after pop", 32'(bus.rx_ready), 32'h1);
            for (int k = 1; k < 4; k++) begin
                check_vec("t5 order", 32'(bus.iport), 32'(r * 16 + k));
                bus.port_rd = 1'b1;
                step();
                bus.port_rd = 1'b0;
            end
            check_vec("t5 drained", 32'(bus.iport), 32'h80);
        end

        // Concurrent push+pop: TX full, RX at 2
        st_q[0] = 8'hD1; st_q[1] = 8'hD2; st_q[2] = 8'hD3; st_q[3] = 8'hD4;
        do_stores(4);
        step();
        bus.rx_valid = 1'b1;
        bus.rx_data = 7'h41;
        step();
        bus.rx_data = 7'h42;
        step();
        bus.rx_valid = 1'b0;
        bus.port_wr = 1'b1;
        step();
        bus.oport = 8'hD5;
        bus.port_wr = 1'b0;
        bus.tx_ready = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data = 7'h43;
        bus.port_rd = 1'b1;
        check_vec("t6 iport sampled", 32'(bus.iport), 32'h41);
        check_vec("t6 tx head", 32'(bus.tx_data), 32'hD1);
        step();
        bus.tx_ready = 1'b0;
        bus.rx_valid = 1'b0;
        bus.port_rd = 1'b0;
        check_vec("t6 no ovf", 32'(bus.tx_ovf), 32'h0);
        check_vec("t6 rx ready", 32'(bus.rx_ready), 32'h1);
        st_q[0] = 8'hD2; st_q[1] = 8'hD3; st_q[2] = 8'hD4; st_q[3] = 8'hD5;
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_vec("t6 tx order", 32'(bus.tx_data), 32'(st_q[i]));
            step();
        end
        bus.tx_ready = 1'b0;
        check_vec("t6 tx empty", 32'(bus.tx_valid), 32'h0);
        check_vec("t6 rx 42", 32'(bus.iport), 32'h42);
        bus.port_rd = 1'b1;
        step();
        check_vec("t6 rx 43", 32'(bus.iport), 32'h43);
        step();
        bus.port_rd = 1'b0;
        check_vec("t6 rx empty", 32'(bus.iport), 32'h80);

        // Asynchronous reset with traffic queued
        st_q[0] = 8'hE1; st_q[1] = 8'hE2; st_q[2] = 8'hE3; st_q[3] = 8'hE4; st_q[4] = 8'hE5;
        do_stores(5);
        step();
        bus.rx_valid = 1'b1;
        bus.rx_data = 7'h11;
        step();
        bus.rx_data = 7'h22;
        step();
        bus.rx_valid = 1'b0;
        check_vec("t1 pre tx_valid", 32'(bus.tx_valid), 32'h1);
        check_vec("t1 pre tx_ovf", 32'(bus.tx_ovf), 32'h1);
        check_vec("t1 pre iport", 32'(bus.iport), 32'h11);
        #3 rst_n = 1'b0;
        #1;
        check_vec("t1 async iport",    32'(bus.iport),    32'h80);
        check_vec("t1 async tx_valid", 32'(bus.tx_valid), 32'h0);
        check_vec("t1 async rx_ready", 32'(bus.rx_ready), 32'h1);
        check_vec("t1 async tx_ovf",   32'(bus.tx_ovf),   32'h0);
        #3 rst_n = 1'b1;
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_vec("t1 no tx after rst", 32'(bus.tx_valid), 32'h0);
            check_vec("t1 no rx after rst", 32'(bus.iport), 32'h80);
        end
        bus.tx_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
